// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the ID stage of a five-stage MIPS pipeline: load-use stalls,
// multi-cycle mul wait and branch flush. Optional macro HAZARD_PERF_CNT_EN adds a stall counter.
module pipeline_hazard_controller #(
    parameter int MUL_LATENCY = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic        ID_IsMul,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_RegDest,
    input  logic        EX_BranchTaken,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Write,
    output logic        IDEX_Bubble,
    output logic        MulBusy,
    output logic        MulDone,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0] StallCycles,
`endif
    output logic        state_dbg
);

    localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          load_use;

    assign state_dbg = state;

    // $zero is never a real producer, so it can never create a hazard.
    assign load_use = EX_MemRead && (EX_RegDest != 5'd0) &&
                      ((EX_RegDest == ID_Rs) || (ID_UsesRt && (EX_RegDest == ID_Rt)));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        MulBusy     = 1'b0;
        MulDone     = 1'b0;

        if (Reset) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (EX_BranchTaken) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Bubble = 1'b1;
                    end else if (load_use) begin
                        PCWrite     = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end else if (ID_IsMul && (MUL_LATENCY > 1)) begin
                        state_next = MUL_WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
                MUL_WAIT: begin
                    // EX is occupied by the mul; hazard and branch inputs are meaningless here.
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_Write = 1'b0;
                    MulBusy    = 1'b1;
                    cnt_next   = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        MulDone    = 1'b1;
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            StallCycles <= '0;
        end else if (!PCWrite && (StallCycles != 16'hFFFF)) begin
            StallCycles <= StallCycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MUL_LATENCY=4): vector table plus
// hand-written mul, back-to-back, reset-abort and optional stall-counter sequences.
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_dest;
    logic        id_uses_rt, id_is_mul, ex_mem_read, ex_br;
    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic        mul_busy, mul_done, state_dbg;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.MUL_LATENCY(4)) dut (
        .Clock(clk), .Reset(rst),
        .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt), .ID_IsMul(id_is_mul),
        .EX_MemRead(ex_mem_read), .EX_RegDest(ex_dest), .EX_BranchTaken(ex_br),
        .PCWrite(pc_write), .IFID_Write(ifid_write), .IFID_Flush(ifid_flush),
        .IDEX_Write(idex_write), .IDEX_Bubble(idex_bubble),
        .MulBusy(mul_busy), .MulDone(mul_done),
`ifdef HAZARD_PERF_CNT_EN
        .StallCycles(stall_cycles),
`endif
        .state_dbg(state_dbg)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       is_mul;
        logic       mem_read;
        logic [4:0] dest;
        logic       br;
        logic [4:0] exp; // {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble}
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic is_mul, input logic mem_read, input logic [4:0] dest,
                         input logic br);
        id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_is_mul = is_mul;
        ex_mem_read = mem_read; ex_dest = dest; ex_br = br;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Checks the five pipeline controls plus MulBusy/MulDone.
    task automatic check_out(input string name, input logic [4:0] exp_ctl,
                             input logic exp_busy, input logic exp_done);
        check({name, ".ctl"}, 16'({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}),
              16'(exp_ctl));
        check({name, ".busy"}, 16'(mul_busy), 16'(exp_busy));
        check({name, ".done"}, 16'(mul_done), 16'(exp_done));
    endtask

    localparam logic [4:0] NORMAL = 5'b11010;
    localparam logic [4:0] STALL  = 5'b00011;
    localparam logic [4:0] FLUSH  = 5'b11111;
    localparam logic [4:0] FROZEN = 5'b00000;
    localparam logic [4:0] IN_RST = 5'b00011;

    initial begin
        vecs[0] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, NORMAL};
        vecs[1] = '{5'd20, 5'd3,  1'b0, 1'b0, 1'b1, 5'd20, 1'b0, STALL};
        vecs[2] = '{5'd4,  5'd7,  1'b1, 1'b0, 1'b1, 5'd7,  1'b0, STALL};
        vecs[3] = '{5'd4,  5'd20, 1'b0, 1'b0, 1'b1, 5'd20, 1'b0, NORMAL};
        vecs[4] = '{5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, NORMAL};
        vecs[5] = '{5'd20, 5'd0,  1'b0, 1'b0, 1'b0, 5'd20, 1'b0, NORMAL};
        vecs[6] = '{5'd1,  5'd2,  1'b1, 1'b0, 1'b0, 5'd9,  1'b1, FLUSH};
        vecs[7] = '{5'd20, 5'd5,  1'b1, 1'b1, 1'b1, 5'd20, 1'b1, FLUSH};
        vecs[8] = '{5'd8,  5'd9,  1'b1, 1'b1, 1'b1, 5'd9,  1'b0, STALL};
        vecs[9] = '{5'd6,  5'd7,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, NORMAL};

        // Reset behaviour
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        check_out("reset", IN_RST, 1'b0, 1'b0);
        check("reset.state", 16'(state_dbg), 16'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("perf.reset", stall_cycles, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Combinational vectors from RUN; none of them may leave RUN
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].is_mul,
                  vecs[i].mem_read, vecs[i].dest, vecs[i].br);
            #2;
            check_out($sformatf("vec%0d", i), vecs[i].exp, 1'b0, 1'b0);
            @(posedge clk); #1;
            check($sformatf("vec%0d.state", i), 16'(state_dbg), 16'd0);
            @(negedge clk);
        end

        // Load-use then release (perf: 1 stall cycle)
        idle();
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        drive(5'd20, 5'd0, 1'b0, 1'b0, 1'b1, 5'd20, 1'b0);
        #2; check_out("lu.stall", STALL, 1'b0, 1'b0);
        @(negedge clk);
        drive(5'd20, 5'd0, 1'b0, 1'b0, 1'b0, 5'd20, 1'b0);
        #2; check_out("lu.release", NORMAL, 1'b0, 1'b0);

        // mul 0x72119802: rs=16 rt=17; wait cycles ignore hostile inputs (perf: +3)
        @(negedge clk);
        drive(5'd16, 5'd17, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        #2; check_out("mul.issue", NORMAL, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(5'd20, 5'd20, 1'b1, 1'b1, 1'b1, 5'd20, 1'b1);
            #2; check_out($sformatf("mul.wait%0d", i), FROZEN, 1'b1, logic'(i == 2));
        end
        @(negedge clk);
        idle();
        #2; check_out("mul.after", NORMAL, 1'b0, 1'b0);
        check("mul.after.state", 16'(state_dbg), 16'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("perf.count", stall_cycles, 16'd4);
`endif

        // Back-to-back mul: second issues on first RUN cycle after MulDone
        @(negedge clk);
        drive(5'd16, 5'd17, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        #2; check_out("b2b.issue1", NORMAL, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            check_out($sformatf("b2b.wait%0d", i), FROZEN, 1'b1, logic'(i == 2));
        end
        @(negedge clk); #2;
        check_out("b2b.issue2", NORMAL, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        #2; check_out("b2b.wait_again", FROZEN, 1'b1, 1'b0);

        // Reset on the 2nd wait cycle aborts the wait
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(5'd16, 5'd17, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        #2; check_out("rstmul.issue", NORMAL, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        #2; check_out("rstmul.wait0", FROZEN, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #2; check_out("rstmul.in_reset", IN_RST, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #2; check_out("rstmul.after", NORMAL, 1'b0, 1'b0);
        check("rstmul.state", 16'(state_dbg), 16'd0);
        @(negedge clk); #2;
        check_out("rstmul.stay_run", NORMAL, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequences the five-stage MIPS pipeline around the Instruction_Decode stage. Detects load-use hazards, runs a multi-cycle stall for `mul`, and flushes the fetch/decode path on taken branches. It drives the write enables, holds and bubbles of the PC, IF/ID and ID/EX registers. The block holds the multiply-wait state machine and its cycle counter.

## Interface
- MUL_LATENCY, 4, EX-stage cycles a `mul` occupies, ≥1
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- ID_Rs  in  5  rs field of instruction in ID
- ID_Rt  in  5  rt field of instruction in ID
- ID_UsesRt  in  1  ID instruction reads rt as a source
- ID_IsMul  in  1  ID instruction is `mul` (opcode 0x1C, funct 0x02)
- EX_MemRead  in  1  instruction in EX is a load
- EX_RegDest  in  5  destination register of instruction in EX
- EX_BranchTaken  in  1  branch resolved taken in EX
- PCWrite  out  1  PC update enable
- IFID_Write  out  1  IF/ID load enable
- IFID_Flush  out  1  clear IF/ID to nop
- IDEX_Write  out  1  ID/EX load enable (0 = hold)
- IDEX_Bubble  out  1  load ID/EX with zeroed control
- MulBusy  out  1  multiplier occupying EX
- MulDone  out  1  final multiply cycle

## Operation
- States: RUN, MUL_WAIT. The counter is max(1,$clog2(MUL_LATENCY)) bits wide.
- Load-use hazard (LU): EX_MemRead && EX_RegDest≠0 && (EX_RegDest==ID_Rs || (ID_UsesRt && EX_RegDest==ID_Rt)).
- RUN decisions, in priority order:
  - EX_BranchTaken: PCWrite=1, IFID_Write=1, IFID_Flush=1, IDEX_Write=1, IDEX_Bubble=1. Any `mul` in ID is discarded and the state stays RUN.
  - LU: PCWrite=0, IFID_Write=0, IDEX_Write=1, IDEX_Bubble=1. The state stays RUN. The hazard clears the next cycle because a bubble is now in EX.
  - ID_IsMul with MUL_LATENCY>1: normal advance (all writes 1, flush and bubble 0). Next state is MUL_WAIT, with the counter loaded to MUL_LATENCY-1.
  - Otherwise: PCWrite=IFID_Write=IDEX_Write=1, IFID_Flush=IDEX_Bubble=0.
- MUL_WAIT:
  - Outputs: PCWrite=IFID_Write=IDEX_Write=0, IFID_Flush=IDEX_Bubble=0, MulBusy=1.
  - The counter decrements each cycle.
  - When the counter is 1: MulDone=1, and the next state is RUN.
  - All hazard and branch inputs are ignored in this state, because EX holds the `mul`.
- MUL_LATENCY=1: MUL_WAIT is never entered, and MulBusy and MulDone stay 0.
- Register $zero never causes a stall.

## Timing
- State and counter update on the rising Clock edge.
- Outputs are combinational from registered state and current inputs, so a stall is effective in the same cycle the hazard appears.
- While Reset=1: PCWrite=0, IFID_Write=0, IFID_Flush=0, IDEX_Write=1, IDEX_Bubble=1, MulBusy=0, MulDone=0.
- The first edge with Reset=1 sets the state to RUN and the counter to 0.
- Reset during MUL_WAIT aborts the wait immediately. MulDone is not pulsed.
- Load-use stall: exactly 1 cycle per hazard.
- `mul` stall: MUL_LATENCY-1 cycles after the issue cycle. MulDone is high only on the last of those cycles.
- Back-to-back `mul`: the second issues on the first RUN cycle after MulDone.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds output StallCycles [15:0].
  - The counter increments every cycle Reset=0 && PCWrite=0, and saturates at 16'hFFFF.
  - It resets to 0 on Reset.
- HAZARD_PERF_CNT_EN undefined: no port and no counter logic.

## Test plan
- Load-use: EX_MemRead=1, EX_RegDest=20, ID_Rs=20 → same cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1. Next cycle, with EX_MemRead=0, all writes are 1.
- Zero register: EX_MemRead=1, EX_RegDest=0, ID_Rs=0 → no stall. Also ID_UsesRt=0, ID_Rt=20, EX_RegDest=20 → no stall.
- `mul` (0x72119802) with MUL_LATENCY=4: issue cycle normal, then 3 cycles MulBusy=1 with PCWrite=0. MulDone=1 only on the 3rd of those cycles, then RUN.
- Simultaneous: EX_BranchTaken=1 with an LU condition and ID_IsMul=1 → IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, and the state stays RUN.
- Reset asserted on the 2nd MUL_WAIT cycle → reset output values as listed. After Reset deasserts, the state is RUN and MulBusy=0.
- With HAZARD_PERF_CNT_EN: one load-use stall plus one `mul` with MUL_LATENCY=4 → StallCycles=4.
